// File: rtl/display_seq_pkg.sv
// rtl/display_seq_pkg.sv - shared types and constants for the display sequencer
//
// Contents:
//   state_t      sequencer states (IDLE, SHIFT, HOLD)
//   NUM_REQ      number of character requesters
//   ASCII_SPACE  blank character used for reset and clear

package display_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam int          NUM_REQ     = 2;
   localparam logic [7:0]  ASCII_SPACE = 8'h20;

endpackage

// File: rtl/display_seq_arbiter.sv
// rtl/display_seq_arbiter.sv - two-requester arbiter for the display sequencer
//
// Build option: ARB_ROUND_ROBIN_EN
//   defined   : round-robin; on a tie the requester not granted last wins.
//               The pointer only moves when a grant is issued.
//   undefined : fixed priority, requester 0 always wins; no state held.
//
// Ports:
//   i_Clk    clock (round-robin build only)
//   i_Rst_L  asynchronous active-low reset (round-robin build only)
//   req      request vector, bit n = requester n
//   gnt_en   grant may be issued this cycle
//   winner   one-hot winner, all zero when gnt_en is low or no request

module display_seq_arbiter
   import display_seq_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
   input  logic               i_Clk,
   input  logic               i_Rst_L,
`endif
   input  logic [NUM_REQ-1:0] req,
   input  logic               gnt_en,
   output logic [NUM_REQ-1:0] winner
);

`ifdef ARB_ROUND_ROBIN_EN
   // Index of the requester granted last; reset to 1 so requester 0 is favoured.
   logic last_gnt;

   always_comb begin
      winner = '0;
      if (gnt_en) begin
         if (&req)
            winner = last_gnt ? 2'b01 : 2'b10;
         else if (req[0])
            winner = 2'b01;
         else if (req[1])
            winner = 2'b10;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L)
         last_gnt <= 1'b1;
      else if (|winner)
         last_gnt <= winner[1];
   end
`else
   always_comb begin
      winner = '0;
      if (gnt_en) begin
         if (req[0])
            winner = 2'b01;
         else if (req[1])
            winner = 2'b10;
      end
   end
`endif

endmodule

// File: rtl/display_sequencer.sv
// rtl/display_sequencer.sv - grants one character at a time onto a two-digit display
//
// Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (see display_seq_arbiter); default is fixed priority to requester 0.
//
// Parameters:
//   HOLD_CYCLES  cycles a new character is held before the next grant (>= 1)
//
// Ports:
//   i_Clk        clock, rising edge
//   i_Rst_L      asynchronous active-low reset
//   i_Req        request vector, bit n = requester n
//   i_Char_0/1   ASCII character offered by requester 0/1
//   i_Clear      synchronous clear of both digits, overrides everything
//   o_Gnt        one-cycle one-hot grant pulse
//   o_Char_Tens  left digit character
//   o_Char_Ones  right digit character
//   o_Update     one-cycle pulse whenever the display changes
//   o_Busy       high while not idle

module display_sequencer
   import display_seq_pkg::*;
#(
   parameter int HOLD_CYCLES = 25000000
) (
   input  logic               i_Clk,
   input  logic               i_Rst_L,
   input  logic [NUM_REQ-1:0] i_Req,
   input  logic [7:0]         i_Char_0,
   input  logic [7:0]         i_Char_1,
   input  logic               i_Clear,
   output logic [NUM_REQ-1:0] o_Gnt,
   output logic [7:0]         o_Char_Tens,
   output logic [7:0]         o_Char_Ones,
   output logic               o_Update,
   output logic               o_Busy
);

   localparam int               CNT_W     = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t               state;
   logic [CNT_W-1:0]     hold_cnt;
   logic [7:0]           latched_char;
   logic [NUM_REQ-1:0]   arb_winner;
   logic                 arb_gnt_en;
   logic [7:0]           winner_char;

   // A clear on the same edge blocks the grant, so the arbiter pointer
   // must not advance either.
   assign arb_gnt_en  = (state == ST_IDLE) && !i_Clear && (|i_Req);
   assign winner_char = arb_winner[1] ? i_Char_1 : i_Char_0;

   display_seq_arbiter u_arbiter (
`ifdef ARB_ROUND_ROBIN_EN
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
`endif
      .req     (i_Req),
      .gnt_en  (arb_gnt_en),
      .winner  (arb_winner)
   );

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state        <= ST_IDLE;
         hold_cnt     <= '0;
         latched_char <= ASCII_SPACE;
         o_Gnt        <= '0;
         o_Char_Tens  <= ASCII_SPACE;
         o_Char_Ones  <= ASCII_SPACE;
         o_Update     <= 1'b0;
         o_Busy       <= 1'b0;
      end else if (i_Clear) begin
         // Any character latched in SHIFT is dropped; its grant is spent.
         state        <= ST_IDLE;
         hold_cnt     <= '0;
         latched_char <= ASCII_SPACE;
         o_Gnt        <= '0;
         o_Char_Tens  <= ASCII_SPACE;
         o_Char_Ones  <= ASCII_SPACE;
         o_Update     <= 1'b1;
         o_Busy       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               o_Update <= 1'b0;
               o_Gnt    <= arb_winner;
               if (|arb_winner) begin
                  latched_char <= winner_char;
                  state        <= ST_SHIFT;
                  o_Busy       <= 1'b1;
               end
            end
            ST_SHIFT: begin
               o_Gnt       <= '0;
               o_Char_Tens <= o_Char_Ones;
               o_Char_Ones <= latched_char;
               o_Update    <= 1'b1;
               hold_cnt    <= HOLD_LOAD;
               state       <= ST_HOLD;
            end
            ST_HOLD: begin
               o_Update <= 1'b0;
               // Loaded with HOLD_CYCLES-1 so HOLD spans exactly HOLD_CYCLES cycles.
               if (hold_cnt == '0) begin
                  state  <= ST_IDLE;
                  o_Busy <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt - CNT_ONE;
               end
            end
            default: begin
               state    <= ST_IDLE;
               o_Gnt    <= '0;
               o_Update <= 1'b0;
               o_Busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/display_sequencer.md
DISPLAY_SEQUENCER -- requirements
Module: display_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 25000000, cycles a new character is held before the next grant; legal range >= 1.
REQ-002 SHALL have port i_Clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_Req  input  2  per-requester character request, bit n = requester n.
REQ-005 SHALL have port i_Char_0  input  8  ASCII character from requester 0.
REQ-006 SHALL have port i_Char_1  input  8  ASCII character from requester 1.
REQ-007 SHALL have port i_Clear  input  1  synchronous display clear.
REQ-008 SHALL have port o_Gnt  output  2  one-hot grant pulse, bit n = requester n.
REQ-009 SHALL have port o_Char_Tens  output  8  left-digit ASCII character.
REQ-010 SHALL have port o_Char_Ones  output  8  right-digit ASCII character.
REQ-011 SHALL have port o_Update  output  1  one-cycle pulse on display change.
REQ-012 SHALL have port o_Busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, SHIFT, HOLD; all outputs registered.
REQ-014 IDLE, any i_Req bit high at edge k: o_Gnt = winner one-hot, winner's char latched, state SHIFT; o_Gnt visible in cycle k..k+1 only.
REQ-015 SHIFT at edge k+1: o_Gnt 0, o_Char_Tens <= o_Char_Ones, o_Char_Ones <= latched char, o_Update 1, hold counter <= HOLD_CYCLES-1, state HOLD.
REQ-016 HOLD: o_Update 0; counter decrements each edge; edge with counter == 0 -> IDLE; HOLD occupies exactly HOLD_CYCLES cycles.
REQ-017 Earliest next grant edge after grant at edge k SHALL be k+2+HOLD_CYCLES.
REQ-018 Requests outside IDLE SHALL be ignored (not queued); requester holds i_Req until granted, drops it the cycle after o_Gnt.
REQ-019 i_Clear high at an edge, any state: both chars <= 8'h20, o_Gnt 0, o_Update 1, state IDLE; overrides any simultaneous request.
REQ-020 i_Clear in SHIFT: latched character SHALL be discarded (grant already consumed).
REQ-021 Hold counter width SHALL be $clog2(HOLD_CYCLES+1); no wrap below 0.
REQ-022 Characters SHALL pass unmodified; no ASCII validation.

Reset
REQ-023 i_Rst_L low SHALL asynchronously force: state IDLE, o_Gnt 0, o_Update 0, o_Busy 0, o_Char_Tens/o_Char_Ones 8'h20, counter 0, latched char 8'h20, arbiter pointer favouring requester 0.
REQ-024 Reset deassertion mid-HOLD SHALL resume from IDLE; first grant no earlier than first edge after deassertion.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN defined: round-robin; on simultaneous requests the requester not granted last wins; pointer updates only on a grant.
REQ-026 ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins; no pointer register.

Structure
REQ-027 Package display_seq_pkg SHALL hold state enum, NUM_REQ = 2, ASCII_SPACE = 8'h20.
REQ-028 Arbitration SHALL be one sub-module display_seq_arbiter (request vector, grant-enable in, one-hot winner out, pointer internal).

Verification (HOLD_CYCLES = 4)
REQ-029 Reset release -> o_Char_Tens = o_Char_Ones = 8'h20, o_Busy 0, o_Gnt 0.
REQ-030 i_Req=01, i_Char_0="1" then "2" after grant -> o_Gnt 01 one cycle each; display " 1" then "12"; grants 6 edges apart.
REQ-031 i_Req=11 held, chars "A"/"B" -> RR: grants 01,10,01; fixed: 01,01,01.
REQ-032 i_Req=10 raised during HOLD -> no grant until IDLE; grant on first IDLE edge.
REQ-033 i_Clear pulsed in SHIFT with "7" latched -> display "  ", o_Update 1, state IDLE, "7" never displayed.
REQ-034 i_Rst_L low mid-HOLD with display "34" -> immediate "  ", o_Busy 0 without clock edge.
